// File: rtl/fpu_wb_queue_if.sv
// Signal bundle between the FPU writeback merge stage and its neighbours:
// pipeline lanes, long-op unit, flush control, register-file write ports.
interface fpu_wb_queue_if #(
  parameter int DEPTH   = 4,
  parameter int REG_NUM = 32,
  parameter int FMT_W   = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               pipe1_we;
  logic [4:0]         pipe1_waddr;
  logic [31:0]        pipe1_wdata;
  logic [FMT_W-1:0]   pipe1_fmt;
  logic               pipe2_we;
  logic [4:0]         pipe2_waddr;
  logic [31:0]        pipe2_wdata;
  logic [FMT_W-1:0]   pipe2_fmt;
  logic               lissue_valid;
  logic [4:0]         lissue_addr;
  logic               lres_valid;
  logic               lres_ready;
  logic [4:0]         lres_addr;
  logic [31:0]        lres_val;
  logic [FMT_W-1:0]   lres_fmt;
  logic               lres_epoch;
  logic               flush;
  logic               epoch;
  logic               wr1_we;
  logic [4:0]         wr1_waddr;
  logic [31:0]        wr1_wdata;
  logic [FMT_W-1:0]   wr1_fmt;
  logic               wr2_we;
  logic [4:0]         wr2_waddr;
  logic [31:0]        wr2_wdata;
  logic [FMT_W-1:0]   wr2_fmt;
  logic [REG_NUM-1:0] busy_vec;
  logic [CW-1:0]      fifo_count;

  modport master (
    output pipe1_we, pipe1_waddr, pipe1_wdata, pipe1_fmt,
    output pipe2_we, pipe2_waddr, pipe2_wdata, pipe2_fmt,
    output lissue_valid, lissue_addr,
    output lres_valid, lres_addr, lres_val, lres_fmt, lres_epoch, flush,
    input  lres_ready, epoch,
    input  wr1_we, wr1_waddr, wr1_wdata, wr1_fmt,
    input  wr2_we, wr2_waddr, wr2_wdata, wr2_fmt,
    input  busy_vec, fifo_count
  );

  modport slave (
    input  pipe1_we, pipe1_waddr, pipe1_wdata, pipe1_fmt,
    input  pipe2_we, pipe2_waddr, pipe2_wdata, pipe2_fmt,
    input  lissue_valid, lissue_addr,
    input  lres_valid, lres_addr, lres_val, lres_fmt, lres_epoch, flush,
    output lres_ready, epoch,
    output wr1_we, wr1_waddr, wr1_wdata, wr1_fmt,
    output wr2_we, wr2_waddr, wr2_wdata, wr2_fmt,
    output busy_vec, fifo_count
  );
endinterface

// File: rtl/fpu_wb_queue.sv
// FPU writeback merge: lane pass-through, long-result FIFO drained into idle
// write ports, per-register busy scoreboard and flush epoch.
module fpu_wb_queue #(
  parameter int DEPTH   = 4,
  parameter int REG_NUM = 32,
  parameter int FMT_W   = 2
) (
  input logic          clk,
  input logic          rst,
  fpu_wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [4:0]         addr_q [DEPTH];
  logic [31:0]        val_q  [DEPTH];
  logic [FMT_W-1:0]   fmt_q  [DEPTH];
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               epoch_q, epoch_d;

  logic ready_s, push_s, pop_s, drain_en_s, drain1_s, drain2_s;

  // Handshake and drain steering; wr1 is preferred for the drain.
  always_comb begin
    ready_s    = (cnt_q < FULL_C) && !rst;
    drain_en_s = (cnt_q != (AW+1)'(0)) && !bus.flush && !rst;
    drain1_s   = drain_en_s && !bus.pipe1_we;
    drain2_s   = drain_en_s && bus.pipe1_we && !bus.pipe2_we;
    pop_s      = drain1_s || drain2_s;
    // Stale-epoch or flush-cycle beats are consumed but never stored.
    push_s     = bus.lres_valid && ready_s && (bus.lres_epoch == epoch_q) && !bus.flush;
  end

  // Write-port muxing: lane first, otherwise FIFO head, otherwise idle zeros.
  always_comb begin
    bus.wr1_we = 1'b0; bus.wr1_waddr = 5'd0; bus.wr1_wdata = 32'd0; bus.wr1_fmt = '0;
    bus.wr2_we = 1'b0; bus.wr2_waddr = 5'd0; bus.wr2_wdata = 32'd0; bus.wr2_fmt = '0;
    if (!rst && bus.pipe1_we) begin
      bus.wr1_we = 1'b1; bus.wr1_waddr = bus.pipe1_waddr;
      bus.wr1_wdata = bus.pipe1_wdata; bus.wr1_fmt = bus.pipe1_fmt;
    end else if (drain1_s) begin
      bus.wr1_we = 1'b1; bus.wr1_waddr = addr_q[rd_q];
      bus.wr1_wdata = val_q[rd_q]; bus.wr1_fmt = fmt_q[rd_q];
    end else begin
      bus.wr1_we = 1'b0;
    end
    if (!rst && bus.pipe2_we) begin
      bus.wr2_we = 1'b1; bus.wr2_waddr = bus.pipe2_waddr;
      bus.wr2_wdata = bus.pipe2_wdata; bus.wr2_fmt = bus.pipe2_fmt;
    end else if (drain2_s) begin
      bus.wr2_we = 1'b1; bus.wr2_waddr = addr_q[rd_q];
      bus.wr2_wdata = val_q[rd_q]; bus.wr2_fmt = fmt_q[rd_q];
    end else begin
      bus.wr2_we = 1'b0;
    end
  end

  // Next-state for pointers, occupancy, scoreboard and epoch.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    epoch_d = epoch_q;
    if (bus.flush) begin
      epoch_d = ~epoch_q;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      busy_d  = '0;
    end else begin
      if (push_s) wr_d = wr_q + AW'(1);
      else        wr_d = wr_q;
      if (pop_s)  rd_d = rd_q + AW'(1);
      else        rd_d = rd_q;
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      // Clear before set so a same-cycle issue to the drained register wins.
      if (pop_s) busy_d[addr_q[rd_q]] = 1'b0;
      else       busy_d = busy_q;
      if (bus.lissue_valid) busy_d[bus.lissue_addr] = 1'b1;
      else                  busy_d = busy_d;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
      epoch_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      epoch_q <= epoch_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_q[wr_q] <= bus.lres_addr;
      val_q[wr_q]  <= bus.lres_val;
      fmt_q[wr_q]  <= bus.lres_fmt;
    end
  end

  assign bus.lres_ready = ready_s;
  assign bus.epoch      = epoch_q;
  assign bus.busy_vec   = busy_q;
  assign bus.fifo_count = cnt_q;
endmodule

// File: tb/tb_fpu_wb_queue.sv
// Directed bench for fpu_wb_queue: reset, drain steering, backpressure,
// flush/epoch filtering and scoreboard set/clear collision.
module tb_fpu_wb_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  fpu_wb_queue_if #(.DEPTH(4), .REG_NUM(32), .FMT_W(2)) bus ();

  fpu_wb_queue #(.DEPTH(4), .REG_NUM(32), .FMT_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.pipe1_we = 1'b1; bus.pipe1_waddr = 5'd1; bus.pipe1_wdata = 32'h1111_1111; bus.pipe1_fmt = 2'd1;
    bus.pipe2_we = 1'b0; bus.pipe2_waddr = 5'd2; bus.pipe2_wdata = 32'h2222_2222; bus.pipe2_fmt = 2'd2;
    bus.lissue_valid = 1'b0; bus.lissue_addr = 5'd0;
    bus.lres_valid = 1'b1; bus.lres_addr = 5'd6; bus.lres_val = 32'hDEAD_BEEF;
    bus.lres_fmt = 2'd0; bus.lres_epoch = 1'b0; bus.flush = 1'b0;

    // Reset held two cycles with traffic presented
    tick();
    chk("rst_ready", 64'(bus.lres_ready), 64'd0);
    chk("rst_wr1_we", 64'(bus.wr1_we), 64'd0);
    chk("rst_wr2_we", 64'(bus.wr2_we), 64'd0);
    tick();
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_busy", 64'(bus.busy_vec), 64'd0);
    chk("rst_epoch", 64'(bus.epoch), 64'd0);
    rst = 1'b0; bus.lres_valid = 1'b0; bus.pipe1_we = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.lres_ready), 64'd1);
    chk("idle_wr1_we", 64'(bus.wr1_we), 64'd0);

    // Idle-port drain of r5
    bus.lissue_valid = 1'b1; bus.lissue_addr = 5'd5;
    tick();
    chk("busy5_set", 64'(bus.busy_vec), 64'h20);
    bus.lissue_valid = 1'b0;
    bus.lres_valid = 1'b1; bus.lres_addr = 5'd5; bus.lres_val = 32'h3F80_0000; bus.lres_epoch = 1'b0;
    #1;
    chk("no_bypass_we", 64'(bus.wr1_we), 64'd0);
    tick();
    bus.lres_valid = 1'b0;
    #1;
    chk("drain_count", 64'(bus.fifo_count), 64'd1);
    chk("drain_wr1_we", 64'(bus.wr1_we), 64'd1);
    chk("drain_wr1_addr", 64'(bus.wr1_waddr), 64'd5);
    chk("drain_wr1_data", 64'(bus.wr1_wdata), 64'h3F80_0000);
    chk("drain_wr2_we", 64'(bus.wr2_we), 64'd0);
    tick();
    chk("drain_busy_clr", 64'(bus.busy_vec), 64'd0);
    chk("drain_count0", 64'(bus.fifo_count), 64'd0);
    chk("drain_done_we", 64'(bus.wr1_we), 64'd0);

    // Port steering with r7 queued
    bus.lissue_valid = 1'b1; bus.lissue_addr = 5'd7;
    bus.lres_valid = 1'b1; bus.lres_addr = 5'd7; bus.lres_val = 32'h4000_0000; bus.lres_fmt = 2'd3;
    tick();
    bus.lissue_valid = 1'b0; bus.lres_valid = 1'b0;
    bus.pipe1_we = 1'b1; bus.pipe2_we = 1'b1;
    #1;
    chk("both_wr1_addr", 64'(bus.wr1_waddr), 64'd1);
    chk("both_wr1_data", 64'(bus.wr1_wdata), 64'h1111_1111);
    chk("both_wr2_addr", 64'(bus.wr2_waddr), 64'd2);
    chk("both_wr2_data", 64'(bus.wr2_wdata), 64'h2222_2222);
    tick();
    chk("held_count", 64'(bus.fifo_count), 64'd1);
    chk("held_busy", 64'(bus.busy_vec), 64'h80);
    bus.pipe2_we = 1'b0;
    #1;
    chk("steer_wr1_addr", 64'(bus.wr1_waddr), 64'd1);
    chk("steer_wr2_we", 64'(bus.wr2_we), 64'd1);
    chk("steer_wr2_addr", 64'(bus.wr2_waddr), 64'd7);
    chk("steer_wr2_data", 64'(bus.wr2_wdata), 64'h4000_0000);
    chk("steer_wr2_fmt", 64'(bus.wr2_fmt), 64'd3);
    tick();
    chk("steer_count0", 64'(bus.fifo_count), 64'd0);
    chk("steer_busy0", 64'(bus.busy_vec), 64'd0);

    // Fill to DEPTH while both lanes are busy
    bus.pipe2_we = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.lres_valid = 1'b1; bus.lres_addr = 5'(i); bus.lres_val = 32'(i * 256); bus.lres_fmt = 2'd0;
      tick();
    end
    chk("full_count", 64'(bus.fifo_count), 64'd4);
    chk("full_ready", 64'(bus.lres_ready), 64'd0);
    bus.lres_addr = 5'd20;
    tick();
    chk("full_hold_count", 64'(bus.fifo_count), 64'd4);
    bus.lres_valid = 1'b0;
    bus.pipe1_we = 1'b0; bus.pipe2_we = 1'b0;
    #1;
    chk("order_addr1", 64'(bus.wr1_waddr), 64'd1);
    chk("order_data1", 64'(bus.wr1_wdata), 64'h100);
    tick();
    chk("ready_after_pop", 64'(bus.lres_ready), 64'd1);
    chk("count_after_pop", 64'(bus.fifo_count), 64'd3);
    chk("order_addr2", 64'(bus.wr1_waddr), 64'd2);
    tick();
    chk("order_addr3", 64'(bus.wr1_waddr), 64'd3);
    tick();
    chk("order_addr4", 64'(bus.wr1_waddr), 64'd4);
    chk("order_data4", 64'(bus.wr1_wdata), 64'h400);
    tick();
    chk("empty_count", 64'(bus.fifo_count), 64'd0);
    chk("empty_wr1_we", 64'(bus.wr1_we), 64'd0);

    // Flush with r3 pending; issue in the flush cycle is ignored
    bus.lissue_valid = 1'b1; bus.lissue_addr = 5'd3;
    bus.lres_valid = 1'b1; bus.lres_addr = 5'd3; bus.lres_val = 32'hC000_0000;
    tick();
    bus.lres_valid = 1'b0;
    bus.lissue_addr = 5'd4;
    bus.flush = 1'b1;
    bus.pipe2_we = 1'b1;
    #1;
    chk("flush_no_drain", 64'(bus.wr1_we), 64'd0);
    chk("flush_pass_wr2", 64'(bus.wr2_waddr), 64'd2);
    tick();
    bus.flush = 1'b0; bus.lissue_valid = 1'b0; bus.pipe2_we = 1'b0;
    #1;
    chk("flush_epoch", 64'(bus.epoch), 64'd1);
    chk("flush_count", 64'(bus.fifo_count), 64'd0);
    chk("flush_busy", 64'(bus.busy_vec), 64'd0);
    chk("flush_wr1_we", 64'(bus.wr1_we), 64'd0);
    bus.lres_valid = 1'b1; bus.lres_addr = 5'd3; bus.lres_epoch = 1'b0;
    #1;
    chk("stale_ready", 64'(bus.lres_ready), 64'd1);
    tick();
    bus.lres_valid = 1'b0;
    #1;
    chk("stale_dropped", 64'(bus.fifo_count), 64'd0);
    chk("stale_wr1_we", 64'(bus.wr1_we), 64'd0);

    // Set/clear collision on r9
    bus.lres_valid = 1'b1; bus.lres_addr = 5'd9; bus.lres_val = 32'h4120_0000; bus.lres_epoch = 1'b1;
    tick();
    bus.lres_valid = 1'b0;
    bus.lissue_valid = 1'b1; bus.lissue_addr = 5'd9;
    #1;
    chk("coll_wr1_we", 64'(bus.wr1_we), 64'd1);
    chk("coll_wr1_addr", 64'(bus.wr1_waddr), 64'd9);
    tick();
    bus.lissue_valid = 1'b0;
    #1;
    chk("coll_busy", 64'(bus.busy_vec), 64'h200);
    chk("coll_count", 64'(bus.fifo_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
